// File: rtl/paddle_input_ctrl_pkg.sv
// Playfield geometry and bat constants shared by the paddle input block, game controller and renderer.
// Coordinates are 11 bits with y increasing downward.
package paddle_input_ctrl_pkg;

  localparam int COORD_W    = 11;
  localparam int DB_CNT_W   = 20;
  localparam int TICK_CNT_W = 17;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_ext_t;

  localparam coord_t Y_TOP    = 11'd30;
  localparam coord_t Y_BOT    = 11'd450;
  localparam coord_t Y_CENTRE = 11'd240;

  localparam coord_t HH_BASE  = 11'd4;
  localparam coord_t HH_SMALL = 11'd15;
  localparam coord_t HH_LARGE = 11'd25;

  function automatic coord_ext_t half_height(input logic small_bat);
    return {1'b0, HH_BASE} + (small_bat ? {1'b0, HH_SMALL} : {1'b0, HH_LARGE});
  endfunction

  function automatic coord_t clamp_y(input coord_ext_t v, input coord_ext_t lo,
                                     input coord_ext_t hi);
    coord_ext_t r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/paddle_input_ctrl_btn_debounce.sv
// One push-button: 2-flop synchroniser followed by a counter-based debouncer.
// Output level changes only after the synchronised input differs for DB_CYCLES consecutive cycles.
module btn_debounce
  import paddle_input_ctrl_pkg::*;
#(
  parameter logic [DB_CNT_W-1:0] DB_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic lvl_o
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CYCLES - DB_CNT_W'(1);

  logic                sync1_q, sync2_q;
  logic                db_q, db_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == DB_LAST) db_d = sync2_q;
      else                  cnt_d = cnt_q + DB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lvl_o = db_q;

endmodule

// File: rtl/paddle_input_ctrl.sv
// Raw up/down buttons -> debounced, rate-limited, clamped paddle centre positions for both players.
// Defining PADDLE_AUTO_P2_EN makes player 2 a computer opponent that tracks ball_y.
module paddle_input_ctrl
  import paddle_input_ctrl_pkg::*;
#(
  parameter logic [DB_CNT_W-1:0]   DB_CYCLES = 20'd500000,
  parameter logic [TICK_CNT_W-1:0] MOVE_DIV  = 17'd100000,
  parameter coord_t                STEP      = 11'd2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p1_up,
  input  logic         p1_dn,
  input  logic         p2_up,
  input  logic         p2_dn,
  input  logic         bat_size,
  input  logic         start_state,
  input  logic [10:0]  ball_y,
  output logic [10:0]  p1_y,
  output logic [10:0]  p2_y,
  output logic         move_tick
);

  localparam coord_ext_t STEP_X = {1'b0, STEP};
  localparam logic [TICK_CNT_W-1:0] TICK_LAST = MOVE_DIV - TICK_CNT_W'(1);

  logic [TICK_CNT_W-1:0] tick_q, tick_d;
  coord_t                p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  coord_t                p1_step, p2_step;
  coord_ext_t            lo, hi;
  logic                  p1_up_db, p1_dn_db;

  // 12-bit arithmetic keeps y-STEP from wrapping near zero.
  function automatic coord_t btn_step(input coord_t y, input logic up, input logic dn,
                                      input coord_ext_t lo_l, input coord_ext_t hi_l);
    coord_ext_t y_x;
    y_x = {1'b0, y};
    if (up && !dn)      y_x = (y_x < lo_l + STEP_X) ? lo_l : y_x - STEP_X;
    else if (dn && !up) y_x = (y_x + STEP_X > hi_l) ? hi_l : y_x + STEP_X;
    return y_x[COORD_W-1:0];
  endfunction

  assign lo = {1'b0, Y_TOP} + half_height(bat_size);
  assign hi = {1'b0, Y_BOT} - half_height(bat_size);

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_p1_up (.clk(clk), .rst(rst), .btn_i(p1_up), .lvl_o(p1_up_db));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_p1_dn (.clk(clk), .rst(rst), .btn_i(p1_dn), .lvl_o(p1_dn_db));

  assign p1_step = btn_step(p1_y_q, p1_up_db, p1_dn_db, lo, hi);

`ifdef PADDLE_AUTO_P2_EN
  logic       unused_p2_btn;
  coord_ext_t p2_x, ball_x, p2_seek;

  assign unused_p2_btn = p2_up ^ p2_dn;
  assign p2_x   = {1'b0, p2_y_q};
  assign ball_x = {1'b0, ball_y};

  // Snap onto the ball once it is closer than one step, otherwise chase it by STEP.
  always_comb begin
    p2_seek = ball_x;
    if (ball_x > p2_x && ball_x - p2_x >= STEP_X)      p2_seek = p2_x + STEP_X;
    else if (ball_x < p2_x && p2_x - ball_x >= STEP_X) p2_seek = p2_x - STEP_X;
  end

  assign p2_step = clamp_y(p2_seek, lo, hi);
`else
  logic unused_ball;
  logic p2_up_db, p2_dn_db;

  assign unused_ball = ^ball_y;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_p2_up (.clk(clk), .rst(rst), .btn_i(p2_up), .lvl_o(p2_up_db));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_p2_dn (.clk(clk), .rst(rst), .btn_i(p2_dn), .lvl_o(p2_dn_db));

  assign p2_step = btn_step(p2_y_q, p2_up_db, p2_dn_db, lo, hi);
`endif

  assign move_tick = (tick_q == TICK_LAST);

  // Out-of-range clamp runs every cycle so a bat size change takes effect without waiting for a tick.
  always_comb begin
    tick_d = move_tick ? '0 : tick_q + TICK_CNT_W'(1);
    p1_y_d = p1_y_q;
    p2_y_d = p2_y_q;
    if (start_state) begin
      p1_y_d = Y_CENTRE;
      p2_y_d = Y_CENTRE;
    end else begin
      if ({1'b0, p1_y_q} < lo || {1'b0, p1_y_q} > hi) p1_y_d = clamp_y({1'b0, p1_y_q}, lo, hi);
      else if (move_tick)                             p1_y_d = p1_step;
      if ({1'b0, p2_y_q} < lo || {1'b0, p2_y_q} > hi) p2_y_d = clamp_y({1'b0, p2_y_q}, lo, hi);
      else if (move_tick)                             p2_y_d = p2_step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q <= '0;
      p1_y_q <= Y_CENTRE;
      p2_y_q <= Y_CENTRE;
    end else begin
      tick_q <= tick_d;
      p1_y_q <= p1_y_d;
      p2_y_q <= p2_y_d;
    end
  end

  assign p1_y = p1_y_q;
  assign p2_y = p2_y_q;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Scoreboard bench for paddle_input_ctrl: each expected paddle position is queued by the stimulus
// and popped by a monitor whenever the DUT presents a new p1_y/p2_y value.
module tb_paddle_input_ctrl;
  import paddle_input_ctrl_pkg::*;

  localparam logic [19:0] DBC  = 20'd4;
  localparam logic [16:0] MDIV = 17'd8;
  localparam int          STP  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic        bat_size = 1'b0;
  logic        start_state = 1'b0;
  logic [10:0] ball_y = 11'd240;
  logic [10:0] p1_y, p2_y;
  logic        move_tick;

  int tests = 0;
  int fails = 0;

  logic [10:0] p1_q[$];
  logic [10:0] p2_q[$];
  logic [10:0] p1_prev, p2_prev;

  always #5 clk = ~clk;

  paddle_input_ctrl #(.DB_CYCLES(DBC), .MOVE_DIV(MDIV), .STEP(11'd2)) dut (
    .clk(clk), .rst(rst),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .bat_size(bat_size), .start_state(start_state), .ball_y(ball_y),
    .p1_y(p1_y), .p2_y(p2_y), .move_tick(move_tick)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every change of a paddle output must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      p1_prev = p1_y;
      p2_prev = p2_y;
    end else begin
      if (p1_y !== p1_prev) begin
        if (p1_q.size() == 0) check("p1_y unexpected change", int'(p1_y), int'(p1_prev));
        else                  check("p1_y sequence", int'(p1_y), int'(p1_q.pop_front()));
        p1_prev = p1_y;
      end
      if (p2_y !== p2_prev) begin
        if (p2_q.size() == 0) check("p2_y unexpected change", int'(p2_y), int'(p2_prev));
        else                  check("p2_y sequence", int'(p2_y), int'(p2_q.pop_front()));
        p2_prev = p2_y;
      end
    end
  end

  // Queue a saturating ramp from 'from' toward 'lim' in STP steps (excluding 'from').
  task automatic push_ramp(input int player, input int from, input int lim);
    int v;
    v = from;
    while (v != lim) begin
      if (lim < v) v = (v - STP < lim) ? lim : v - STP;
      else         v = (v + STP > lim) ? lim : v + STP;
      if (player == 1) p1_q.push_back(11'(v));
      else             p2_q.push_back(11'(v));
    end
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n;
    n = 0;
    while ((p1_q.size() + p2_q.size()) != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, p1_q.size() + p2_q.size(), 0);
  endtask

  // Called right after reset release on a negedge; the tick shows once the counter reaches MOVE_DIV-1.
  task automatic check_first_tick(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!move_tick && n < 100);
    check(name, n, int'(MDIV) - 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset p1_y", int'(p1_y), 240);
    check("reset p2_y", int'(p2_y), 240);
    check("reset move_tick", int'(move_tick), 0);
    rst = 1'b1;
    check_first_tick("first tick after reset");

    // p1 up with large bat: 240, 238, ... saturating at 59
    @(negedge clk);
    push_ramp(1, 240, 59);
    p1_up = 1'b1;
    wait_drain("p1 up ramp", 1200);
    repeat (40) @(negedge clk);
    check("p1 saturate top large", int'(p1_y), 59);
    p1_up = 1'b0;
    repeat (20) @(negedge clk);

    // Glitch one cycle shorter than the debounce window
    p1_dn = 1'b1;
    repeat (int'(DBC) - 1) @(negedge clk);
    p1_dn = 1'b0;
    repeat (30) @(negedge clk);
    check("p1 glitch ignored", int'(p1_y), 59);

    bat_size = 1'b1;
    repeat (2) @(negedge clk);
`ifdef PADDLE_AUTO_P2_EN
    push_ramp(2, 240, 300);
    ball_y = 11'd300;
    wait_drain("p2 auto chase down", 1500);
    repeat (20) @(negedge clk);
    check("p2 auto holds on ball", int'(p2_y), 300);
    push_ramp(2, 300, 49);
    ball_y = 11'd10;
    wait_drain("p2 auto chase up", 1500);
    repeat (20) @(negedge clk);
    bat_size = 1'b0;
    p2_q.push_back(11'd59);
    @(posedge clk);
    #1;
    check("p2 reclamp on bat change", int'(p2_y), 59);
`else
    push_ramp(2, 240, 431);
    p2_dn = 1'b1;
    wait_drain("p2 down ramp small bat", 1500);
    repeat (20) @(negedge clk);
    check("p2 saturate bottom small", int'(p2_y), 431);
    bat_size = 1'b0;
    p2_q.push_back(11'd421);
    @(posedge clk);
    #1;
    check("p2 reclamp on bat change", int'(p2_y), 421);
    @(negedge clk);
    p2_dn = 1'b0;
`endif
    repeat (20) @(negedge clk);

    // Both buttons held, then a one-cycle start_state recentre
    p1_up = 1'b1;
    p1_dn = 1'b1;
    repeat (20) @(negedge clk);
    start_state = 1'b1;
    p1_q.push_back(11'd240);
    p2_q.push_back(11'd240);
`ifdef PADDLE_AUTO_P2_EN
    ball_y = 11'd240;
`endif
    @(posedge clk);
    #1;
    check("p1 recentre on start", int'(p1_y), 240);
    check("p2 recentre on start", int'(p2_y), 240);
    @(negedge clk);
    start_state = 1'b0;
    repeat (50) @(negedge clk);
    check("p1 holds with both buttons", int'(p1_y), 240);

    // Move, then assert reset mid-movement
    p1_dn = 1'b0;
    push_ramp(1, 240, 234);
    wait_drain("p1 move before reset", 200);
    rst = 1'b0;
    p1_up = 1'b0;
    #1;
    check("mid-move reset p1_y", int'(p1_y), 240);
    check("mid-move reset p2_y", int'(p2_y), 240);
    check("mid-move reset move_tick", int'(move_tick), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_first_tick("first tick after mid-move reset");
    repeat (20) @(negedge clk);
    check("final p1_y", int'(p1_y), 240);
    check("no expectations left", p1_q.size() + p2_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
